mem_port_arbiter: RTL and testbench

- Shares one external memory port between three requesters: instruction-fetch read (port I), memory-access read (port R) and memory-access write (port W).
- Sits between the pipeline stages' memory interfaces and the single downstream memory/cache port.
- Sequences one transaction at a time: fixed priority W > R > I, with an anti-starvation counter that protects fetch.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/arb_prio_sel.sv | 22 ++
 rtl/mem_port_arbiter.sv | 79 +++++++
 tb/tb_mem_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and default widths for the memory port arbiter
//   state_t : arbiter FSM states
//   gnt_t   : index of each requester within a one-hot grant vector
package mem_port_arbiter_pkg;
    localparam int ADDR_L = 32;
    localparam int DATA_L = 32;
    localparam int LEN_L = 2;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RELEASE = 2'd2
    } state_t;
    typedef enum logic [1:0] {
        GNT_I = 2'd0,
        GNT_R = 2'd1,
        GNT_W = 2'd2
    } gnt_t;
    // Collapse a one-hot grant vector into its requester index.
    function automatic gnt_t gnt_enc(input logic [2:0] oh);
        return oh[GNT_W] ? GNT_W : oh[GNT_R] ? GNT_R : GNT_I;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the memory port arbiter
//   i_* : fetch read port      (i_re, i_addr, i_len in; i_dout, i_ack out)
//   r_* : MA read port         (r_re, r_addr, r_len in; r_dout, r_ack out)
//   w_* : MA write port        (w_we, w_addr, w_len, w_din in; w_ack out)
//   m_* : memory port          (m_re, m_we, m_addr, m_len, m_dout out; m_din, m_ack in)
//   slave : arbiter view, master : view of the requesters plus memory
interface mem_port_arbiter_if #(
    parameter int ADDR_L = mem_port_arbiter_pkg::ADDR_L,
    parameter int DATA_L = mem_port_arbiter_pkg::DATA_L,
    parameter int LEN_L = mem_port_arbiter_pkg::LEN_L
);
    logic i_re;
    logic [ADDR_L-1:0] i_addr;
    logic [LEN_L-1:0] i_len;
    logic [DATA_L-1:0] i_dout;
    logic i_ack;
    logic r_re;
    logic [ADDR_L-1:0] r_addr;
    logic [LEN_L-1:0] r_len;
    logic [DATA_L-1:0] r_dout;
    logic r_ack;
    logic w_we;
    logic [ADDR_L-1:0] w_addr;
    logic [LEN_L-1:0] w_len;
    logic [DATA_L-1:0] w_din;
    logic w_ack;
    logic m_re;
    logic m_we;
    logic [ADDR_L-1:0] m_addr;
    logic [LEN_L-1:0] m_len;
    logic [DATA_L-1:0] m_dout;
    logic [DATA_L-1:0] m_din;
    logic m_ack;
    modport slave (
        input i_re, i_addr, i_len, output i_dout, i_ack,
        input r_re, r_addr, r_len, output r_dout, r_ack,
        input w_we, w_addr, w_len, w_din, output w_ack,
        output m_re, m_we, m_addr, m_len, m_dout, input m_din, m_ack
    );
    modport master (
        output i_re, i_addr, i_len, input i_dout, i_ack,
        output r_re, r_addr, r_len, input r_dout, r_ack,
        output w_we, w_addr, w_len, w_din, input w_ack,
        input m_re, m_we, m_addr, m_len, m_dout, output m_din, m_ack
    );
endinterface

// File: rtl/arb_prio_sel.sv
// arb_prio_sel: fixed-priority W > R > I selector with a starvation override for I
//   i_req, r_req, w_req : requests
//   starve              : I has waited its allowed number of grants
//   gnt                 : one-hot grant, indexed by gnt_t
module arb_prio_sel
    import mem_port_arbiter_pkg::*;
(
    input  logic       i_req,
    input  logic       r_req,
    input  logic       w_req,
    input  logic       starve,
    output logic [2:0] gnt
);
    logic force_i;
    always_comb begin
        force_i = i_req && starve;
        gnt = '0;
        gnt[GNT_W] = w_req && !force_i;
        gnt[GNT_R] = r_req && !w_req && !force_i;
        gnt[GNT_I] = i_req && (force_i || (!w_req && !r_req));
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch read, MA read and MA write
//   clk : clock, rising edge
//   rst : asynchronous reset, active-low
//   bus : requester and memory signals (mem_port_arbiter_if.slave)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W = 3
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    state_t state;
    gnt_t sel;
    logic [CNT_W-1:0] cnt;
    logic [2:0] gnt;
    logic starve;
    assign starve = (cnt == CNT_W'(STARVE_MAX));
    arb_prio_sel u_sel (
        .i_req(bus.i_re),
        .r_req(bus.r_re),
        .w_req(bus.w_we),
        .starve(starve),
        .gnt(gnt)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sel <= GNT_I;
            cnt <= '0;
            bus.i_ack <= 1'b0;
            bus.r_ack <= 1'b0;
            bus.w_ack <= 1'b0;
            bus.i_dout <= '0;
            bus.r_dout <= '0;
            bus.m_re <= 1'b0;
            bus.m_we <= 1'b0;
            bus.m_addr <= '0;
            bus.m_len <= '0;
            bus.m_dout <= '0;
        end else begin
            bus.i_ack <= 1'b0;
            bus.r_ack <= 1'b0;
            bus.w_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // With i_re high some port always wins, so a non-I grant is an R/W grant made while I waits.
                    if (!bus.i_re || gnt[GNT_I]) cnt <= '0;
                    else if (!starve) cnt <= cnt + 1'b1;
                    if (|gnt) begin
                        sel <= gnt_enc(gnt);
                        state <= BUSY;
                        bus.m_re <= !gnt[GNT_W];
                        bus.m_we <= gnt[GNT_W];
                        bus.m_addr <= gnt[GNT_W] ? bus.w_addr : gnt[GNT_R] ? bus.r_addr : bus.i_addr;
                        bus.m_len <= gnt[GNT_W] ? bus.w_len : gnt[GNT_R] ? bus.r_len : bus.i_len;
                        if (gnt[GNT_W]) bus.m_dout <= bus.w_din;
                    end
                end
                BUSY: begin
                    if (bus.m_ack) begin
                        bus.m_re <= 1'b0;
                        bus.m_we <= 1'b0;
                        bus.i_ack <= (sel == GNT_I);
                        bus.r_ack <= (sel == GNT_R);
                        bus.w_ack <= (sel == GNT_W);
                        if (sel == GNT_I) bus.i_dout <= bus.m_din;
                        if (sel == GNT_R) bus.r_dout <= bus.m_din;
                        state <= RELEASE;
                    end
                end
                // RELEASE: one cycle with no grant so the acked requester can drop its request.
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;
    localparam int SMAX = 4;
    localparam logic [31:0] I_A = 32'h100;
    localparam logic [31:0] R_A = 32'h200;
    localparam logic [31:0] W_A = 32'h300;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_L(ADDR_L), .DATA_L(DATA_L), .LEN_L(LEN_L)) bus ();
    mem_port_arbiter #(.STARVE_MAX(SMAX), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // model: which port owns the memory (-1 none), the post-completion gap, and I's waiting streak
    int owner, streak, age, delay;
    bit gap;
    logic e_re, e_we;
    logic [2:0] e_ack;
    logic [31:0] e_addr, e_dout, e_idout, e_rdout;
    logic [1:0] e_len;

    // requesters (0=I 1=R 2=W) and memory
    bit req[3], done[3], rereq[3];
    logic [31:0] addr[3];
    logic [1:0] len[3];
    logic [31:0] wdata, m_din, fix_din;
    logic m_ack;
    bit use_fix;
    int p_new, p_drop, p_spur, d_min, d_max;

    // monitor
    int cyc = 0;
    int t0;
    int t_ack[3];
    bit prev_act = 0;
    logic [31:0] log_addr[$];
    int log_cyc[$];
    int mack_cyc[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, want);
        end
    endtask

    function automatic logic [31:0] la(input int i);
        return i < log_addr.size() ? log_addr[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic int lc(input int i);
        return i < log_cyc.size() ? log_cyc[i] : -1;
    endfunction

    function automatic int mc(input int i);
        return i < mack_cyc.size() ? mack_cyc[i] : -100;
    endfunction

    function automatic void model_reset();
        owner = -1;
        gap = 0;
        streak = 0;
        {e_re, e_we, e_ack, e_addr, e_len, e_dout, e_idout, e_rdout} = '0;
        for (int p = 0; p < 3; p++) begin
            req[p] = 0;
            done[p] = 0;
        end
        m_ack = 0;
        prev_act = 0;
    endfunction

    function automatic void clear_mon();
        log_addr.delete();
        log_cyc.delete();
        mack_cyc.delete();
        for (int p = 0; p < 3; p++) t_ack[p] = 0;
    endfunction

    task automatic drive();
        bus.i_re = req[0];
        bus.i_addr = addr[0];
        bus.i_len = len[0];
        bus.r_re = req[1];
        bus.r_addr = addr[1];
        bus.r_len = len[1];
        bus.w_we = req[2];
        bus.w_addr = addr[2];
        bus.w_len = len[2];
        bus.w_din = wdata;
        bus.m_ack = m_ack;
        bus.m_din = m_din;
    endtask

    // One transaction at a time: a completed one leaves one dead cycle, then the
    // highest-ranked waiting port wins (W, R, I), unless I has already watched
    // SMAX R/W grants go by.
    task automatic model_step();
        e_ack = '0;
        if (owner >= 0) begin
            if (m_ack) begin
                e_re = 0;
                e_we = 0;
                e_ack[owner] = 1;
                if (owner == 0) e_idout = m_din;
                if (owner == 1) e_rdout = m_din;
                owner = -1;
                gap = 1;
            end
        end else if (gap) begin
            gap = 0;
        end else begin
            int win = -1;
            if (req[0] && streak >= SMAX) win = 0;
            else if (req[2]) win = 2;
            else if (req[1]) win = 1;
            else if (req[0]) win = 0;
            streak = (!req[0] || win == 0) ? 0 : (streak < SMAX ? streak + 1 : SMAX);
            if (win >= 0) begin
                owner = win;
                age = 0;
                delay = int'($urandom_range(d_max, d_min));
                e_re = (win != 2);
                e_we = (win == 2);
                e_addr = addr[win];
                e_len = len[win];
                if (win == 2) e_dout = wdata;
            end
        end
    endtask

    task automatic check_all();
        check("ctl", 64'({bus.m_re, bus.m_we, bus.w_ack, bus.r_ack, bus.i_ack}),
              64'({e_re, e_we, e_ack[2], e_ack[1], e_ack[0]}));
        check("m_addr", 64'(bus.m_addr), 64'(e_addr));
        check("m_len", 64'(bus.m_len), 64'(e_len));
        check("m_dout", 64'(bus.m_dout), 64'(e_dout));
        check("i_dout", 64'(bus.i_dout), 64'(e_idout));
        check("r_dout", 64'(bus.r_dout), 64'(e_rdout));
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if ((bus.m_re || bus.m_we) && !prev_act) begin
            log_addr.push_back(bus.m_addr);
            log_cyc.push_back(cyc);
        end
        prev_act = bus.m_re || bus.m_we;
        if (bus.i_ack) t_ack[0] = cyc;
        if (bus.r_ack) t_ack[1] = cyc;
        if (bus.w_ack) t_ack[2] = cyc;
        check_all();
        for (int p = 0; p < 3; p++) begin
            if (done[p]) begin
                done[p] = 0;
                req[p] = rereq[p];
            end else if (!req[p] && $urandom_range(99) < p_new) begin
                req[p] = 1;
                addr[p] = $urandom;
                len[p] = 2'($urandom);
                if (p == 2) wdata = $urandom;
            end else if (req[p] && owner != p && !e_ack[p] && $urandom_range(99) < p_drop) begin
                req[p] = 0;
            end
            if (e_ack[p]) done[p] = 1;
        end
        m_din = use_fix ? fix_din : $urandom;
        if (owner >= 0) begin
            m_ack = (age >= delay);
            age++;
            if (m_ack) mack_cyc.push_back(cyc);
        end else begin
            m_ack = ($urandom_range(99) < p_spur);
        end
        drive();
        model_step();
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (req[0] || req[1] || req[2] || done[0] || done[1] || done[2] || owner >= 0 || gap); k++)
            step();
        repeat (2) step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int p = 0; p < 3; p++) begin
            rereq[p] = 0;
            addr[p] = '0;
            len[p] = '0;
        end
        wdata = '0;
        m_din = '0;
        fix_din = '0;
        use_fix = 0;
        p_new = 0;
        p_drop = 0;
        p_spur = 0;
        d_min = 0;
        d_max = 0;
        model_reset();
        clear_mon();
        drive();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;
        model_step();
        repeat (2) step();

        // single fetch, memory answers 2 cycles after m_re
        clear_mon();
        d_min = 2;
        d_max = 2;
        use_fix = 1;
        fix_din = 32'hDEAD_BEEF;
        req[0] = 1;
        addr[0] = I_A;
        len[0] = 2'd2;
        step();
        t0 = cyc;
        for (int k = 0; k < 20 && t_ack[0] == 0; k++) step();
        check("fetch_mre_cyc", 64'(lc(0) - t0), 64'(1));
        check("fetch_addr", 64'(la(0)), 64'(I_A));
        check("fetch_ack_cyc", 64'(t_ack[0] - t0), 64'(4));
        check("fetch_dout", 64'(bus.i_dout), 64'h0000_0000_DEAD_BEEF);
        use_fix = 0;
        drain();
        check("fetch_no_rw_ack", 64'({t_ack[1] != 0, t_ack[2] != 0}), 64'(0));

        // I and R together: R first, I granted 3 cycles after R's m_ack
        clear_mon();
        d_min = 1;
        d_max = 1;
        req[0] = 1;
        addr[0] = I_A;
        req[1] = 1;
        addr[1] = R_A;
        step();
        for (int k = 0; k < 40 && t_ack[0] == 0; k++) step();
        check("cont_first", 64'(la(0)), 64'(R_A));
        check("cont_second", 64'(la(1)), 64'(I_A));
        check("cont_gap", 64'(lc(1) - mc(0)), 64'(3));
        drain();

        // W and R together: W first with its data, R acked afterwards
        clear_mon();
        req[2] = 1;
        addr[2] = W_A;
        wdata = 32'h1234_5678;
        req[1] = 1;
        addr[1] = R_A;
        step();
        step();
        check("wr_we", 64'({bus.m_we, bus.m_re}), 64'(2));
        check("wr_dout", 64'(bus.m_dout), 64'h0000_0000_1234_5678);
        check("wr_addr", 64'(bus.m_addr), 64'(W_A));
        for (int k = 0; k < 40 && t_ack[1] == 0; k++) step();
        check("wr_order", 64'(t_ack[2] > 0 && t_ack[1] > t_ack[2]), 64'(1));
        drain();

        // I held while R keeps re-requesting: 4 R grants, then I, then R again
        clear_mon();
        d_min = 0;
        d_max = 2;
        rereq[1] = 1;
        req[0] = 1;
        addr[0] = I_A;
        req[1] = 1;
        addr[1] = R_A;
        step();
        for (int k = 0; k < 200 && log_addr.size() < 7; k++) step();
        rereq[1] = 0;
        for (int g = 0; g < 4; g++) check("starve_r", 64'(la(g)), 64'(R_A));
        check("starve_i", 64'(la(4)), 64'(I_A));
        check("starve_resume", 64'(la(5)), 64'(R_A));
        drain();

        // I pulsed for one cycle while W is busy: never served
        clear_mon();
        d_min = 6;
        d_max = 6;
        req[2] = 1;
        addr[2] = W_A;
        step();
        step();
        req[0] = 1;
        addr[0] = I_A;
        step();
        req[0] = 0;
        drain();
        check("drop_no_iack", 64'(t_ack[0]), 64'(0));
        check("drop_one_txn", 64'(log_addr.size()), 64'(1));

        // reset while a read is in flight, then re-grant of the still-pending R
        clear_mon();
        d_min = 10;
        d_max = 10;
        req[1] = 1;
        addr[1] = R_A;
        repeat (3) step();
        check("pre_rst_mre", 64'(bus.m_re), 64'(1));
        #2 rst = 1'b0;
        #1;
        check("rst_mre", 64'({bus.m_re, bus.m_we}), 64'(0));
        check("rst_maddr", 64'(bus.m_addr), 64'(0));
        check("rst_acks", 64'({bus.i_ack, bus.r_ack, bus.w_ack}), 64'(0));
        model_reset();
        req[1] = 1;
        drive();
        @(negedge clk);
        cyc++;
        check_all();
        rst = 1'b1;
        model_step();
        step();
        check("rst_regrant", 64'({bus.m_re, bus.m_addr}), {31'd0, 1'b1, R_A});
        d_min = 0;
        d_max = 3;
        drain();

        // randomized traffic with early drops and stray m_ack pulses
        p_new = 30;
        p_drop = 5;
        p_spur = 10;
        repeat (3000) step();
        p_new = 0;
        p_drop = 0;
        p_spur = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
